mem_fill_fsm: RTL and testbench

MEM_FILL_FSM -- requirements
Module: mem_fill_fsm

---
 rtl/mem_fill_fsm.sv | 138 +++++++++++++
 tb/tb_mem_fill_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_fsm.sv
// mem_fill_fsm: walks an inclusive address range (wrapping through the top of
// the address space) and presents one write per address, using one of four
// data patterns. Each write advances only when the memory port grants it.
module mem_fill_fsm #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_val,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              wr_grant,
    input  logic              abort,
    output logic              wr_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              fin_strobe
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_UPDATE = 2'b01;
    localparam logic [1:0] ST_DONE   = 2'b10;

    localparam logic [1:0] MODE_IDENT = 2'b00;
    localparam logic [1:0] MODE_CONST = 2'b01;
    localparam logic [1:0] MODE_INV   = 2'b10;

    // Control state (reset)
    logic [1:0]        state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [ADDR_W:0]   index_q,  index_d;   // one extra bit so a full-depth count fits
    logic [1:0]        mode_q,   mode_d;

    // Latched operands (data only, loaded on every accepted start)
    logic [DATA_W-1:0] fill_val_q, fill_val_d;
    logic [ADDR_W-1:0] end_addr_q, end_addr_d;

    logic              wr_accept;

    // Pattern generator: identity is the address zero-extended or truncated to
    // DATA_W; ramp adds the write index to the seed modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] fill_data(
        input logic [1:0]        m,
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W:0]   idx,
        input logic [DATA_W-1:0] fv
    );
        logic [ADDR_W+DATA_W-1:0] a_ext;
        logic [ADDR_W+DATA_W:0]   i_ext;
        logic [DATA_W-1:0]        ident;
        a_ext = {{DATA_W{1'b0}}, a};
        i_ext = {{DATA_W{1'b0}}, idx};
        ident = a_ext[DATA_W-1:0];
        case (m)
            MODE_IDENT: fill_data = ident;
            MODE_CONST: fill_data = fv;
            MODE_INV:   fill_data = ~ident;
            default:    fill_data = fv + i_ext[DATA_W-1:0];
        endcase
    endfunction

    assign wr_accept = wr_en & wr_grant;

    // Next-state and datapath update: start in IDLE, advance on grant, abort wins over finish.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        index_d    = index_q;
        mode_d     = mode_q;
        fill_val_d = fill_val_q;
        end_addr_d = end_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_UPDATE;
                    mode_d     = mode;
                    fill_val_d = fill_val;
                    end_addr_d = end_addr;
                    addr_d     = start_addr;
                    index_d    = '0;
                end
            end
            ST_UPDATE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (wr_accept) begin
                    if (addr_q == end_addr_q) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        index_d = index_q + (ADDR_W+1)'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            index_q <= '0;
            mode_q  <= MODE_IDENT;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            index_q <= index_d;
            mode_q  <= mode_d;
        end
    end

    // Operand registers; only meaningful after a start, so no reset needed.
    always_ff @(posedge clk) begin
        fill_val_q <= fill_val_d;
        end_addr_q <= end_addr_d;
    end

    // Outputs decoded straight from the registered state.
    always_comb begin
        wr_en      = (state_q == ST_UPDATE);
        busy       = (state_q == ST_UPDATE) || (state_q == ST_DONE);
        fin_strobe = (state_q == ST_DONE);
        addr       = addr_q;
        wr_data    = fill_data(mode_q, addr_q, index_q, fill_val_q);
    end

endmodule

// File: tb/tb_mem_fill_fsm.sv
// Testbench for mem_fill_fsm: directed and randomized fills checked against a
// range/pattern model computed from the fill rules.
module tb_mem_fill_fsm;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [DW-1:0] fill_val;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          wr_grant;
    logic          abort;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          fin_strobe;

    int tests = 0;
    int fails = 0;

    mem_fill_fsm #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .fill_val   (fill_val),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .wr_grant   (wr_grant),
        .abort      (abort),
        .wr_en      (wr_en),
        .addr       (addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .fin_strobe (fin_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: k-th write of a fill goes to start+k (mod 256).
    function automatic logic [7:0] ref_addr(input logic [7:0] sa, input int k);
        return 8'(int'(sa) + k);
    endfunction

    function automatic logic [7:0] ref_data(input logic [1:0] m, input logic [7:0] fv,
                                           input logic [7:0] sa, input int k);
        logic [7:0] a;
        a = ref_addr(sa, k);
        case (m)
            2'd0:    return a;
            2'd1:    return fv;
            2'd2:    return ~a;
            default: return 8'(int'(fv) + k);
        endcase
    endfunction

    function automatic int ref_count(input logic [7:0] sa, input logic [7:0] ea);
        return ((int'(ea) - int'(sa) + 256) % 256) + 1;
    endfunction

    // Entered and left at a negedge with the DUT idle. Starts a fill, grants
    // writes (none for the first stall_n cycles, then with pct% chance), and
    // forces a granted abort on write number abort_k (-1 for none).
    task automatic run_fill(input logic [1:0] m, input logic [7:0] fv, input logic [7:0] sa,
                            input logic [7:0] ea, input int pct, input int stall_n, input int abort_k);
        int n;
        int k;
        int cyc;
        int exp_writes;
        bit g;
        bit ab;
        bit done;
        n          = ref_count(sa, ea);
        exp_writes = (abort_k >= 0 && abort_k < n) ? abort_k + 1 : n;
        start      = 1'b1;
        mode       = m;
        fill_val   = fv;
        start_addr = sa;
        end_addr   = ea;
        wr_grant   = 1'($urandom_range(1));
        abort      = 1'($urandom_range(1));
        k    = 0;
        cyc  = 0;
        done = 1'b0;
        @(negedge clk);
        while (!done && cyc < 3000) begin
            start      = 1'($urandom_range(1));
            mode       = 2'($urandom);
            fill_val   = 8'($urandom);
            start_addr = 8'($urandom);
            end_addr   = 8'($urandom);
            chk("upd_wr_en", 32'(wr_en), 32'd1);
            chk("upd_busy", 32'(busy), 32'd1);
            chk("upd_fin", 32'(fin_strobe), 32'd0);
            chk("upd_addr", 32'(addr), 32'(ref_addr(sa, k)));
            chk("upd_data", 32'(wr_data), 32'(ref_data(m, fv, sa, k)));
            if (k == abort_k) begin
                g  = 1'b1;
                ab = 1'b1;
            end else begin
                g  = (cyc >= stall_n) && (int'($urandom_range(99)) < pct);
                ab = 1'b0;
            end
            wr_grant = g;
            abort    = ab;
            @(negedge clk);
            cyc++;
            if (g) begin
                if (ab) begin
                    chk("abort_wr_en", 32'(wr_en), 32'd0);
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_fin", 32'(fin_strobe), 32'd0);
                    done = 1'b1;
                end else if (k == n - 1) begin
                    chk("done_wr_en", 32'(wr_en), 32'd0);
                    chk("done_fin", 32'(fin_strobe), 32'd1);
                    chk("done_busy", 32'(busy), 32'd1);
                    wr_grant = 1'b0;
                    abort    = 1'($urandom_range(1));
                    @(negedge clk);
                    chk("idle_fin", 32'(fin_strobe), 32'd0);
                    chk("idle_busy", 32'(busy), 32'd0);
                    chk("idle_wr_en", 32'(wr_en), 32'd0);
                    done = 1'b1;
                end else begin
                    k++;
                end
            end
        end
        chk("fill_done", 32'(done), 32'd1);
        chk("write_count", 32'(k + 1), 32'(exp_writes));
        start    = 1'b0;
        abort    = 1'b0;
        wr_grant = 1'b0;
    endtask

    initial begin
        int cyc;
        int n;
        int ak;
        logic [7:0] rsa;
        logic [7:0] rea;
        rst        = 1'b1;
        start      = 1'b1;
        mode       = 2'd3;
        fill_val   = 8'h5A;
        start_addr = 8'h33;
        end_addr   = 8'h44;
        wr_grant   = 1'b1;
        abort      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fin", 32'(fin_strobe), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        chk("idle_hold_busy", 32'(busy), 32'd0);
        chk("idle_hold_wr_en", 32'(wr_en), 32'd0);
        abort = 1'b0;

        // Identity full-depth fill
        run_fill(2'd0, 8'h00, 8'h00, 8'hFF, 100, 0, -1);
        // Wrap and ramp
        run_fill(2'd3, 8'h10, 8'hFE, 8'h01, 100, 0, -1);
        // Stall on a single-address fill
        run_fill(2'd1, 8'hA5, 8'h40, 8'h40, 100, 3, -1);
        // Abort mid-fill, then abort on the final write
        run_fill(2'd2, 8'h00, 8'h00, 8'h0F, 100, 0, 5);
        run_fill(2'd2, 8'h00, 8'h00, 8'h0F, 100, 0, 15);

        // Reset mid-fill
        start      = 1'b1;
        mode       = 2'd0;
        start_addr = 8'h00;
        end_addr   = 8'hFF;
        @(negedge clk);
        start    = 1'b0;
        wr_grant = 1'b1;
        cyc      = 0;
        while (addr != 8'h20 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_addr_20", 32'(addr), 32'h20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_addr", 32'(addr), 32'd0);
        chk("midrst_fin", 32'(fin_strobe), 32'd0);
        @(negedge clk);
        chk("postrst_fin", 32'(fin_strobe), 32'd0);
        chk("postrst_busy", 32'(busy), 32'd0);
        wr_grant = 1'b0;

        // Randomized fills
        for (int i = 0; i < 8; i++) begin
            rsa = 8'($urandom);
            rea = 8'(int'(rsa) + int'($urandom_range(40)));
            n   = ref_count(rsa, rea);
            ak  = ($urandom_range(2) == 0) ? int'($urandom_range(n - 1)) : -1;
            run_fill(2'($urandom), 8'($urandom), rsa, rea, 60, int'($urandom_range(3)), ak);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
